irq_ctrl: RTL

Interrupt controller sitting directly downstream of the per-source `irq_gate` instances. It collects their `irq_pending` flags and applies per-source and global enables. It picks one source by fixed priority and runs a request/take handshake with the core's trap logic. When the core takes the trap, it returns a one-cycle `ack` to the chosen gate, so that gate clears its pending flag.

---
 rtl/irq_pkg.sv | 22 ++
 rtl/irq_prio_enc.sv | 22 ++
 rtl/irq_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller.
package irq_pkg;

    // Handshake state of the controller.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HANDLER = 2'd2
    } irq_state_e;

    // mcause bit that flags an interrupt (as opposed to an exception).
    localparam int MCAUSE_INT_BIT = 31;

    // mcause code reported for source 0 by default.
    localparam int IRQ_CAUSE_BASE = 16;

    // Width of a source index; a single source still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set request bit wins.
module irq_prio_enc #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        valid = |req;
        index = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: masks gate pending flags with per-source and global
// enables, arbitrates by fixed priority and runs the request/take handshake
// with the core's trap logic, acknowledging the taken gate for one cycle.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int CAUSE_BASE = IRQ_CAUSE_BASE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] ack,
    input  logic               ie_we,
    input  logic [NUM_SRC-1:0] ie_wdata,
    output logic [NUM_SRC-1:0] ie,
    input  logic               gie_we,
    input  logic               gie_wdata,
    output logic               gie,
    output logic               mpie,
    output logic               trap_req,
    output logic [31:0]        trap_cause,
    input  logic               trap_take,
    input  logic               mret,
    output logic               in_handler
);

    localparam int IDX_W = idx_width(NUM_SRC);
    localparam logic [31:0] INT_FLAG = 32'd1 << MCAUSE_INT_BIT;
    localparam logic [31:0] RESET_CAUSE = INT_FLAG | 32'(CAUSE_BASE);

    irq_state_e         state_reg;
    logic [IDX_W-1:0]   idx_reg;

    logic [NUM_SRC-1:0] elig;
    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;
    logic [31:0]        win_cause;
    logic [NUM_SRC-1:0] idx_onehot;

    logic               take;
    logic [NUM_SRC-1:0] ie_next;
    logic               gie_next;
    logic               mpie_next;
    logic               keep_req;

    assign elig       = pending & ie;
    assign win_cause  = INT_FLAG | (32'(CAUSE_BASE) + 32'(win_idx));
    assign idx_onehot = NUM_SRC'(1) << idx_reg;

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_prio_enc (
        .req   (elig),
        .valid (win_valid),
        .index (win_idx)
    );

    // Next enable values. A take always wins (the core has already committed
    // to the trap); otherwise mret beats a software write to gie.
    always_comb begin
        take      = (state_reg == REQ) && trap_take;
        ie_next   = ie_we ? ie_wdata : ie;
        gie_next  = gie;
        mpie_next = mpie;
        if (take) begin
            gie_next  = 1'b0;
            mpie_next = gie;
        end else if (mret) begin
            gie_next  = mpie;
            mpie_next = 1'b1;
        end else if (gie_we) begin
            gie_next  = gie_wdata;
        end
        // The held request stays up only while it would still be eligible
        // after this cycle's enable updates, so an enable write withdraws it
        // with trap_req dropping on the very next cycle.
        keep_req = gie_next && pending[idx_reg] && ie_next[idx_reg];
    end

    // Per-source enable register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ie <= '0;
        end else begin
            ie <= ie_next;
        end
    end

    // Global enable and its saved copy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gie  <= 1'b0;
            mpie <= 1'b0;
        end else begin
            gie  <= gie_next;
            mpie <= mpie_next;
        end
    end

    // Handshake FSM with registered request, cause, ack and handler flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            ack        <= '0;
            trap_req   <= 1'b0;
            trap_cause <= RESET_CAUSE;
            in_handler <= 1'b0;
        end else begin
            ack <= '0;
            case (state_reg)
                IDLE: begin
                    if (gie && win_valid) begin
                        idx_reg    <= win_idx;
                        trap_cause <= win_cause;
                        trap_req   <= 1'b1;
                        state_reg  <= REQ;
                    end
                end
                REQ: begin
                    if (trap_take) begin
                        ack        <= idx_onehot;
                        trap_req   <= 1'b0;
                        in_handler <= 1'b1;
                        state_reg  <= HANDLER;
                    end else if (!keep_req) begin
                        trap_req   <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                HANDLER: begin
                    if (mret) begin
                        in_handler <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                default: begin
                    trap_req   <= 1'b0;
                    in_handler <= 1'b0;
                    state_reg  <= IDLE;
                end
            endcase
        end
    end

endmodule
